// File: rtl/sub_pipe_64bit.sv
// Pipelined WIDTH-bit subtractor computing a - b - bin as a + ~b + ~bin.
// Each stage resolves one SLICE-bit slice and registers the carry into the next slice.
module sub_pipe_64bit #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             overflow
);

  localparam int unsigned SLICE = WIDTH / STAGES;
  localparam int unsigned SW    = SLICE + 1;
  localparam int unsigned LAST  = STAGES - 1;

  logic             adv;

  logic             v_r  [STAGES];
  logic             c_r  [STAGES];
  logic             am_r [STAGES];
  logic             bm_r [STAGES];
  logic [WIDTH-1:0] a_r  [STAGES];
  logic [WIDTH-1:0] nb_r [STAGES];
  logic [WIDTH-1:0] d_r  [STAGES];
  logic             brw_r;
  logic             ovf_r;

  logic             op_v  [STAGES];
  logic             op_c  [STAGES];
  logic             op_am [STAGES];
  logic             op_bm [STAGES];
  logic [WIDTH-1:0] op_a  [STAGES];
  logic [WIDTH-1:0] op_nb [STAGES];
  logic [WIDTH-1:0] op_d  [STAGES];
  logic [SLICE:0]   sum   [STAGES];

  // Stall is pipeline-wide: everything moves only when the output slot frees up.
  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv & ~rst;

  // Stage operands: stage 0 reads the port, later stages read the previous register.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      assign op_v[k]  = in_valid;
      assign op_c[k]  = ~bin;
      assign op_am[k] = a[WIDTH-1];
      assign op_bm[k] = b[WIDTH-1];
      assign op_a[k]  = a;
      assign op_nb[k] = ~b;
      assign op_d[k]  = '0;
    end else begin : g_next
      assign op_v[k]  = v_r[k-1];
      assign op_c[k]  = c_r[k-1];
      assign op_am[k] = am_r[k-1];
      assign op_bm[k] = bm_r[k-1];
      assign op_a[k]  = a_r[k-1];
      assign op_nb[k] = nb_r[k-1];
      assign op_d[k]  = d_r[k-1];
    end
    assign sum[k] = {1'b0, op_a[k][k*SLICE +: SLICE]}
                  + {1'b0, op_nb[k][k*SLICE +: SLICE]}
                  + SW'(op_c[k]);
  end

  // Stage registers; the last stage also captures borrow and signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]  <= 1'b0;
        c_r[k]  <= 1'b0;
        am_r[k] <= 1'b0;
        bm_r[k] <= 1'b0;
        a_r[k]  <= '0;
        nb_r[k] <= '0;
        d_r[k]  <= '0;
      end
      brw_r <= 1'b0;
      ovf_r <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k]  <= op_v[k];
        c_r[k]  <= sum[k][SLICE];
        am_r[k] <= op_am[k];
        bm_r[k] <= op_bm[k];
        a_r[k]  <= op_a[k];
        nb_r[k] <= op_nb[k];
        d_r[k]  <= op_d[k];
        d_r[k][k*SLICE +: SLICE] <= sum[k][SLICE-1:0];
      end
      brw_r <= ~sum[LAST][SLICE];
      ovf_r <= (op_am[LAST] != op_bm[LAST]) & (sum[LAST][SLICE-1] != op_am[LAST]);
    end
  end

  assign out_valid = v_r[LAST];
  assign diff      = d_r[LAST];
  assign borrow    = brw_r;
  assign overflow  = ovf_r;

endmodule

// File: tb/tb_sub_pipe_64bit.sv
// Self-checking bench for sub_pipe_64bit: directed corner cases, stalled and
// full-rate random streams against an arithmetic reference, and mid-flight reset.
module tb_sub_pipe_64bit;

  localparam int unsigned W = 64;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic [W-1:0] d;
    logic         bw;
    logic         ov;
  } res_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow;
  logic         overflow;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sub_pipe_64bit #(.WIDTH(W), .STAGES(S)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .bin(bin),
    .out_valid(out_valid), .out_ready(out_ready),
    .diff(diff), .borrow(borrow), .overflow(overflow)
  );

  // Reference: plain wide arithmetic, unsigned for borrow and signed range test for overflow.
  function automatic res_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    res_t              r;
    logic [W:0]        u;
    logic signed [W+1:0] s;
    logic signed [W+1:0] smax;
    logic signed [W+1:0] smin;
    smax = 66'sh0_7FFF_FFFF_FFFF_FFFF;
    smin = -66'sh0_8000_0000_0000_0000;
    u    = {1'b0, x} - {1'b0, y} - (W+1)'(c);
    s    = $signed({{2{x[W-1]}}, x}) - $signed({{2{y[W-1]}}, y}) - $signed({{(W+1){1'b0}}, c});
    r.d  = u[W-1:0];
    r.bw = u[W];
    r.ov = (s > smax) || (s < smin);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    tests++;
    if ({out_valid, diff, borrow, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_state got v=%b d=%h bw=%b ov=%b exp all 0", out_valid, diff, borrow, overflow);
    end
    rst = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_single(input string nm, input logic [W-1:0] x, input logic [W-1:0] y,
                             input logic c, input res_t e);
    int edges;
    a = x; b = y; bin = c; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL %s_in_ready got=%b exp=1", nm, in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd64(); b = rnd64(); bin = ~c;
    edges = 0;
    while (out_valid !== 1'b1 && edges < 10) begin
      @(posedge clk); #1;
      edges++;
    end
    tests++;
    if (edges != S - 1) begin fails++; $display("FAIL %s_latency got=%0d exp=%0d edges after accept", nm, edges, S - 1); end
    tests++;
    if (diff !== e.d) begin fails++; $display("FAIL %s_diff got=%h exp=%h", nm, diff, e.d); end
    tests++;
    if ({borrow, overflow} !== {e.bw, e.ov}) begin
      fails++;
      $display("FAIL %s_flags got bw=%b ov=%b exp bw=%b ov=%b", nm, borrow, overflow, e.bw, e.ov);
    end
    @(posedge clk); #1;
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL %s_drain got=%b exp=0", nm, out_valid); end
  endtask

  task automatic test_stream(input int n, input bit stall);
    int   pat [8] = '{1, 0, 0, 1, 1, 0, 1, 1};
    res_t q [$];
    res_t e;
    int   sent = 0, got = 0, cyc = 0;
    bit   acc;
    bit   hold_pending = 1'b0;
    logic [W-1:0] hold_d = '0;
    a = rnd64(); b = rnd64(); bin = 1'($urandom_range(0, 1));
    in_valid = (n > 0);
    while (got < n && cyc < 400) begin
      out_ready = stall ? 1'(pat[cyc % 8]) : 1'b1;
      @(negedge clk);
      if (hold_pending) begin
        tests++;
        if (out_valid !== 1'b1 || diff !== hold_d) begin
          fails++;
          $display("FAIL hold_stable got v=%b d=%h exp v=1 d=%h", out_valid, diff, hold_d);
        end
      end
      hold_pending = 1'b0;
      if (out_valid === 1'b1 && out_ready === 1'b0) begin
        tests++;
        if (in_ready !== 1'b0) begin fails++; $display("FAIL stall_in_ready got=%b exp=0", in_ready); end
        hold_pending = 1'b1;
        hold_d = diff;
      end
      acc = (in_valid === 1'b1 && in_ready === 1'b1);
      if (acc) q.push_back(model(a, b, bin));
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL stream_extra got d=%h exp no result", diff);
        end else begin
          e = q.pop_front();
          if ({diff, borrow, overflow} !== {e.d, e.bw, e.ov}) begin
            fails++;
            $display("FAIL stream_beat%0d got d=%h bw=%b ov=%b exp d=%h bw=%b ov=%b",
                     got, diff, borrow, overflow, e.d, e.bw, e.ov);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      cyc++;
      if (acc) begin
        sent++;
        a = rnd64(); b = rnd64(); bin = 1'($urandom_range(0, 1));
      end
      in_valid = (sent < n);
    end
    tests++;
    if (got != n || q.size() != 0) begin
      fails++;
      $display("FAIL stream_count got=%0d left=%0d exp=%0d left=0", got, q.size(), n);
    end
    if (!stall) begin
      tests++;
      if (cyc != n + S) begin fails++; $display("FAIL stream_rate got=%0d cycles exp=%0d", cyc, n + S); end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset_mid();
    int   stale = 0;
    logic [W-1:0] x, y;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = rnd64(); b = rnd64(); bin = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    a = rnd64(); b = rnd64();
    @(negedge clk);
    tests++;
    if (in_ready !== 1'b0) begin fails++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    in_valid = 1'b0;
    tests++;
    if ({out_valid, diff, borrow, overflow} !== {1'b0, {W{1'b0}}, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL midrst_state got v=%b d=%h bw=%b ov=%b exp all 0", out_valid, diff, borrow, overflow);
    end
    repeat (6) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) stale++;
    end
    tests++;
    if (stale != 0) begin fails++; $display("FAIL midrst_stale got=%0d valid cycles exp=0", stale); end
    x = rnd64(); y = rnd64();
    test_single("post_rst", x, y, 1'b1, model(x, y, 1'b1));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; bin = 1'b0; out_ready = 1'b0;
    test_reset();
    test_single("5m3", 64'd5, 64'd3, 1'b0, '{d: 64'd2, bw: 1'b0, ov: 1'b0});
    test_single("0m1", 64'd0, 64'd1, 1'b0, '{d: 64'hFFFF_FFFF_FFFF_FFFF, bw: 1'b1, ov: 1'b0});
    test_single("7m7b", 64'd7, 64'd7, 1'b1, '{d: 64'hFFFF_FFFF_FFFF_FFFF, bw: 1'b1, ov: 1'b0});
    test_single("min_m1", 64'h8000_0000_0000_0000, 64'd1, 1'b0,
                '{d: 64'h7FFF_FFFF_FFFF_FFFF, bw: 1'b0, ov: 1'b1});
    test_single("max_mneg1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0,
                '{d: 64'h8000_0000_0000_0000, bw: 1'b1, ov: 1'b1});
    test_single("ripple", 64'h0001_0000_0000_0000, 64'd1, 1'b0,
                '{d: 64'h0000_FFFF_FFFF_FFFF, bw: 1'b0, ov: 1'b0});
    test_stream(8, 1'b1);
    test_stream(24, 1'b1);
    test_stream(20, 1'b0);
    test_reset_mid();
    test_stream(8, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
